// File: rtl/lpddr2_pkg.sv
// Shared types and constants for the LPDDR2 memory-stage bridge.
package lpddr2_pkg;

  localparam int LPDDR2_ADDR_W = 27;
  localparam int LPDDR2_DATA_W = 32;
  localparam logic [31:0] LPDDR2_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_CMD,
    DONE
  } lpddr2_state_t;

endpackage

// File: rtl/lpddr2_read_buffer.sv
// One-entry read buffer (valid, tag, data) used by lpddr2_bridge when
// LPDDR2_READ_BUFFER_EN is defined.
module lpddr2_read_buffer
  import lpddr2_pkg::*;
#(
  parameter int ADDR_W = LPDDR2_ADDR_W,
  parameter int DATA_W = LPDDR2_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fill,
  input  logic [ADDR_W-1:0] i_fill_addr,
  input  logic [DATA_W-1:0] i_fill_data,
  input  logic              i_wr_start,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_tag;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
    end else if (i_wr_start && (i_wr_addr == r_tag)) begin
      r_valid <= 1'b0;
    end
  end

  // Tag and payload carry no reset; r_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (i_fill) begin
      r_tag  <= i_fill_addr;
      r_data <= i_fill_data;
    end
  end

  assign o_hit  = r_valid && (i_lookup_addr == r_tag);
  assign o_data = r_data;

endmodule

// File: rtl/lpddr2_bridge.sv
// Memory-stage to LPDDR2 Avalon-MM sequencer with stall and timeout watchdog.
// Define LPDDR2_READ_BUFFER_EN to add a one-entry read buffer.
module lpddr2_bridge
  import lpddr2_pkg::*;
#(
  parameter int ADDR_W  = LPDDR2_ADDR_W,
  parameter int DATA_W  = LPDDR2_DATA_W,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  read_req,
  input  logic                  write_req,
  output logic [DATA_W-1:0]     read_data,
  output logic                  stall,
  output logic                  err,
  input  logic                  avl_ready,
  output logic [ADDR_W-1:0]     avl_addr,
  output logic [DATA_W-1:0]     avl_wdata,
  output logic [DATA_W/8-1:0]   avl_be,
  output logic                  avl_read,
  output logic                  avl_write,
  input  logic                  avl_waitrequest,
  input  logic [DATA_W-1:0]     avl_rdata,
  input  logic                  avl_rdata_valid
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  lpddr2_state_t     r_state;
  lpddr2_state_t     w_next;
  logic [ADDR_W-1:0] r_avl_addr;
  logic [DATA_W-1:0] r_avl_wdata;
  logic              r_avl_read;
  logic              r_avl_write;
  logic [DATA_W-1:0] r_read_data;
  logic              r_err;
  logic [CNT_W-1:0]  r_wd_cnt;

  logic w_busy;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_rd_done;
  logic w_timeout;
  logic w_to_take;
  logic w_start;
  logic w_wr_start;
  logic w_buf_hit;
  logic              w_hit;
  logic [DATA_W-1:0] w_buf_data;

  assign w_busy     = (r_state == RD_CMD) || (r_state == RD_DATA) || (r_state == WR_CMD);
  assign avl_read   = r_avl_read & avl_ready;
  assign avl_write  = r_avl_write & avl_ready;
  assign w_rd_acc   = (r_state == RD_CMD) && avl_read && !avl_waitrequest;
  assign w_wr_acc   = (r_state == WR_CMD) && avl_write && !avl_waitrequest;
  assign w_rd_done  = (r_state == RD_DATA) && avl_rdata_valid;
  assign w_timeout  = w_busy && (r_wd_cnt == CNT_MAX);
  // A command accepted or data returned on the deadline cycle still counts as progress.
  assign w_to_take  = w_timeout && !(w_rd_acc || w_wr_acc || w_rd_done);
  assign w_buf_hit  = (r_state == IDLE) && !write_req && read_req && w_hit;
  assign w_start    = (r_state == IDLE) && ((w_next == RD_CMD) || (w_next == WR_CMD));
  assign w_wr_start = (r_state == IDLE) && write_req;

`ifdef LPDDR2_READ_BUFFER_EN
  lpddr2_read_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_read_buffer (
    .clk           (clk),
    .rst           (rst),
    .i_fill        (w_rd_done),
    .i_fill_addr   (r_avl_addr),
    .i_fill_data   (avl_rdata),
    .i_wr_start    (w_wr_start),
    .i_wr_addr     (address),
    .i_flush       (w_to_take),
    .i_lookup_addr (address),
    .o_hit         (w_hit),
    .o_data        (w_buf_data)
  );
`else
  assign w_hit      = 1'b0;
  assign w_buf_data = '0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (write_req) begin
          w_next = WR_CMD;
        end else if (read_req) begin
          w_next = w_buf_hit ? DONE : RD_CMD;
        end
      end
      RD_CMD: begin
        if (w_rd_acc) begin
          w_next = RD_DATA;
        end else if (w_to_take) begin
          w_next = DONE;
        end
      end
      RD_DATA: begin
        if (w_rd_done || w_to_take) begin
          w_next = DONE;
        end
      end
      WR_CMD: begin
        if (w_wr_acc || w_to_take) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_avl_addr  <= '0;
      r_avl_wdata <= '0;
      r_avl_read  <= 1'b0;
      r_avl_write <= 1'b0;
      r_read_data <= '0;
      r_err       <= 1'b0;
      r_wd_cnt    <= '0;
    end else begin
      r_state     <= w_next;
      r_avl_read  <= (w_next == RD_CMD);
      r_avl_write <= (w_next == WR_CMD);
      if (w_start) begin
        r_avl_addr  <= address;
        r_avl_wdata <= write_data;
        r_wd_cnt    <= '0;
      end else if (w_busy) begin
        r_wd_cnt <= f_sat_inc(r_wd_cnt);
      end
      if (w_to_take) begin
        r_err <= 1'b1;
      end
      if (w_rd_done) begin
        r_read_data <= avl_rdata;
      end else if (w_to_take && (r_state != WR_CMD)) begin
        r_read_data <= DATA_W'(LPDDR2_TIMEOUT_DATA);
      end else if (w_buf_hit) begin
        r_read_data <= w_buf_data;
      end
    end
  end

  // Combinational stall so the core freezes in the same cycle it raises a request.
  assign stall = w_busy || ((r_state == IDLE) && (read_req || write_req));

  assign read_data = r_read_data;
  assign err       = r_err;
  assign avl_addr  = r_avl_addr;
  assign avl_wdata = r_avl_wdata;
  assign avl_be    = '1;

endmodule

// File: tb/tb_lpddr2_bridge.sv
// Self-checking bench for lpddr2_bridge; read buffer scenario follows LPDDR2_READ_BUFFER_EN.
module tb_lpddr2_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] address;
  logic [31:0] write_data;
  logic        read_req;
  logic        write_req;
  logic        avl_ready;
  logic        avl_waitrequest;
  logic [31:0] avl_rdata;
  logic        avl_rdata_valid;

  logic [31:0] read_data, avl_wdata;
  logic [26:0] avl_addr;
  logic [3:0]  avl_be;
  logic        stall, err, avl_read, avl_write;

  logic [31:0] t_read_data, t_avl_wdata;
  logic [26:0] t_avl_addr;
  logic [3:0]  t_avl_be;
  logic        t_stall, t_err, t_avl_read, t_avl_write;

  int n_chk  = 0;
  int n_pass = 0;
  int rd_acc = 0;
  int wr_acc = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  lpddr2_bridge u_dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .read_req(read_req), .write_req(write_req), .read_data(read_data),
    .stall(stall), .err(err), .avl_ready(avl_ready), .avl_addr(avl_addr),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_read(avl_read),
    .avl_write(avl_write), .avl_waitrequest(avl_waitrequest),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid)
  );

  lpddr2_bridge #(.TIMEOUT(15)) u_to (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .read_req(read_req), .write_req(write_req), .read_data(t_read_data),
    .stall(t_stall), .err(t_err), .avl_ready(avl_ready), .avl_addr(t_avl_addr),
    .avl_wdata(t_avl_wdata), .avl_be(t_avl_be), .avl_read(t_avl_read),
    .avl_write(t_avl_write), .avl_waitrequest(avl_waitrequest),
    .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid)
  );

  always @(negedge clk) begin
    if (avl_read && !avl_waitrequest) rd_acc++;
    if (avl_write && !avl_waitrequest) wr_acc++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "bench timed out");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; read_req = 1'b0; write_req = 1'b0; address = '0; write_data = '0;
    avl_ready = 1'b1; avl_waitrequest = 1'b0; avl_rdata = '0; avl_rdata_valid = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
  endtask

  // Reactive Avalon slave: returns data lat cycles after read acceptance; counts stall cycles.
  task automatic run_txn(input int lat, input logic [31:0] data, output int scyc);
    int ci;
    int acc_at;
    ci = 0; acc_at = -1; scyc = 0;
    while (stall === 1'b1 && scyc < 64) begin
      scyc++;
      if (avl_read && !avl_waitrequest && acc_at < 0) acc_at = ci;
      cyc();
      ci++;
      avl_rdata_valid = (acc_at >= 0) && (ci == acc_at + lat);
      avl_rdata = avl_rdata_valid ? data : 32'h0;
      #1;
    end
    avl_rdata_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (read_data !== 32'h0) $display("FAIL rst_read_data: got %h want 0", read_data); else n_pass++;
    n_chk++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
    n_chk++; if (avl_read !== 1'b0 || avl_write !== 1'b0)
      $display("FAIL rst_cmd: got rd=%b wr=%b want 0/0", avl_read, avl_write); else n_pass++;
    n_chk++; if (avl_addr !== 27'h0 || avl_wdata !== 32'h0)
      $display("FAIL rst_addr_data: got %h/%h want 0/0", avl_addr, avl_wdata); else n_pass++;
    n_chk++; if (avl_be !== 4'hF) $display("FAIL rst_be: got %h want f", avl_be); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    address = 27'h100; read_req = 1'b1;
    cyc();
    n_chk++; if (avl_read !== 1'b1 || avl_addr !== 27'h100)
      $display("FAIL mid_rd_cmd: got rd=%b addr=%h want 1/100", avl_read, avl_addr); else n_pass++;
    cyc();
    rst = 1'b0; read_req = 1'b0;
    #1;
    n_chk++; if (stall !== 1'b0 || avl_read !== 1'b0 || err !== 1'b0)
      $display("FAIL mid_rst_ctrl: got stall=%b rd=%b err=%b want 0/0/0", stall, avl_read, err); else n_pass++;
    n_chk++; if (avl_addr !== 27'h0 || read_data !== 32'h0)
      $display("FAIL mid_rst_data: got addr=%h rdata=%h want 0/0", avl_addr, read_data); else n_pass++;
    cyc();
    rst = 1'b1; avl_rdata = 32'h5555_AAAA; avl_rdata_valid = 1'b1;
    cyc();
    avl_rdata_valid = 1'b0; avl_rdata = '0;
    cyc();
    n_chk++; if (read_data !== 32'h0) $display("FAIL mid_late_valid: got %h want 0", read_data); else n_pass++;
    n_chk++; if (stall !== 1'b0 || avl_read !== 1'b0)
      $display("FAIL mid_late_state: got stall=%b rd=%b want 0/0", stall, avl_read); else n_pass++;
  endtask

  task automatic test_write_backpressure();
    int scyc;
    int wcyc;
    int base;
    logic hold_ok;
    do_reset();
    base = wr_acc; scyc = 0; wcyc = 0; hold_ok = 1'b1;
    address = 27'h0800; write_data = 32'h1234_5678; write_req = 1'b1; avl_waitrequest = 1'b1;
    #1;
    while (stall === 1'b1 && scyc < 64) begin
      scyc++;
      cyc();
      avl_waitrequest = (scyc <= 3);
      #1;
      if (avl_write === 1'b1) begin
        wcyc++;
        if (avl_addr !== 27'h0800 || avl_wdata !== 32'h1234_5678) hold_ok = 1'b0;
      end
    end
    n_chk++; if (scyc !== 5) $display("FAIL wr_stall_cycles: got %0d want 5", scyc); else n_pass++;
    n_chk++; if (wcyc !== 4) $display("FAIL wr_cmd_cycles: got %0d want 4", wcyc); else n_pass++;
    n_chk++; if (hold_ok !== 1'b1) $display("FAIL wr_hold_stable: got %b want 1", hold_ok); else n_pass++;
    cyc();
    write_req = 1'b0;
    cyc();
    n_chk++; if (wr_acc - base !== 1) $display("FAIL wr_accept_count: got %0d want 1", wr_acc - base); else n_pass++;
    n_chk++; if (avl_write !== 1'b0) $display("FAIL wr_no_reissue: got %b want 0", avl_write); else n_pass++;
  endtask

  task automatic test_read_latency();
    int scyc;
    int base;
    logic [31:0] exp;
    do_reset();
    base = rd_acc;
    exp_q.push_back(32'hCAFE_F00D);
    address = 27'h0801; read_req = 1'b1;
    #1;
    run_txn(5, 32'hCAFE_F00D, scyc);
    exp = exp_q.pop_front();
    n_chk++; if (read_data !== exp) $display("FAIL rd_lat_data: got %h want %h", read_data, exp); else n_pass++;
    n_chk++; if (scyc !== 7) $display("FAIL rd_lat_stall: got %0d want 7", scyc); else n_pass++;
    n_chk++; if (rd_acc - base !== 1) $display("FAIL rd_lat_accepts: got %0d want 1", rd_acc - base); else n_pass++;
    read_req = 1'b0;
    cyc();
  endtask

  task automatic test_cal_gate();
    int scyc;
    int base;
    logic gate_ok;
    logic [31:0] exp;
    do_reset();
    base = rd_acc; gate_ok = 1'b1;
    avl_ready = 1'b0; address = 27'h0123; read_req = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (avl_read !== 1'b0 || stall !== 1'b1) gate_ok = 1'b0;
      cyc();
    end
    n_chk++; if (gate_ok !== 1'b1) $display("FAIL cal_gate_hold: got %b want 1", gate_ok); else n_pass++;
    avl_ready = 1'b1;
    exp_q.push_back(32'hA5A5_0123);
    #1;
    run_txn(1, 32'hA5A5_0123, scyc);
    exp = exp_q.pop_front();
    n_chk++; if (read_data !== exp) $display("FAIL cal_gate_data: got %h want %h", read_data, exp); else n_pass++;
    n_chk++; if (scyc !== 2) $display("FAIL cal_gate_stall: got %0d want 2", scyc); else n_pass++;
    n_chk++; if (rd_acc - base !== 1) $display("FAIL cal_gate_accepts: got %0d want 1", rd_acc - base); else n_pass++;
    read_req = 1'b0;
    cyc();
  endtask

  task automatic test_timeout();
    int scyc;
    logic [31:0] exp;
    do_reset();
    exp_q.push_back(32'hDEAD_BEEF);
    address = 27'h0456; read_req = 1'b1; scyc = 0;
    #1;
    while (t_stall === 1'b1 && scyc < 64) begin
      scyc++;
      cyc();
    end
    exp = exp_q.pop_front();
    n_chk++; if (scyc !== 17) $display("FAIL to_stall: got %0d want 17", scyc); else n_pass++;
    n_chk++; if (t_err !== 1'b1) $display("FAIL to_err: got %b want 1", t_err); else n_pass++;
    n_chk++; if (t_read_data !== exp) $display("FAIL to_data: got %h want %h", t_read_data, exp); else n_pass++;
    read_req = 1'b0;
    repeat (3) cyc();
    n_chk++; if (t_err !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", t_err); else n_pass++;
  endtask

  task automatic test_read_buffer();
    int scyc;
    int base;
    logic [31:0] exp;
    do_reset();
    exp_q.push_back(32'h1111_0900);
    address = 27'h0900; read_req = 1'b1;
    #1;
    run_txn(2, 32'h1111_0900, scyc);
    exp = exp_q.pop_front();
    n_chk++; if (read_data !== exp) $display("FAIL buf_first_data: got %h want %h", read_data, exp); else n_pass++;
    read_req = 1'b0;
    cyc();
    base = rd_acc;
`ifdef LPDDR2_READ_BUFFER_EN
    exp_q.push_back(32'h1111_0900);
`else
    exp_q.push_back(32'h3333_0900);
`endif
    read_req = 1'b1;
    #1;
    run_txn(2, 32'h3333_0900, scyc);
    exp = exp_q.pop_front();
    n_chk++; if (read_data !== exp) $display("FAIL buf_second_data: got %h want %h", read_data, exp); else n_pass++;
`ifdef LPDDR2_READ_BUFFER_EN
    n_chk++; if (rd_acc - base !== 0) $display("FAIL buf_hit_accepts: got %0d want 0", rd_acc - base); else n_pass++;
    n_chk++; if (scyc !== 1) $display("FAIL buf_hit_stall: got %0d want 1", scyc); else n_pass++;
`else
    n_chk++; if (rd_acc - base !== 1) $display("FAIL buf_off_accepts: got %0d want 1", rd_acc - base); else n_pass++;
    n_chk++; if (scyc !== 4) $display("FAIL buf_off_stall: got %0d want 4", scyc); else n_pass++;
`endif
    read_req = 1'b0;
    cyc();
    write_req = 1'b1; write_data = 32'h0000_0077;
    #1;
    run_txn(1, 32'h0, scyc);
    n_chk++; if (scyc !== 2) $display("FAIL buf_write_stall: got %0d want 2", scyc); else n_pass++;
    write_req = 1'b0;
    cyc();
    base = rd_acc;
    exp_q.push_back(32'h2222_0900);
    read_req = 1'b1;
    #1;
    run_txn(1, 32'h2222_0900, scyc);
    exp = exp_q.pop_front();
    n_chk++; if (read_data !== exp) $display("FAIL buf_after_wr_data: got %h want %h", read_data, exp); else n_pass++;
    n_chk++; if (rd_acc - base !== 1) $display("FAIL buf_after_wr_accepts: got %0d want 1", rd_acc - base); else n_pass++;
    read_req = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_reset_mid_read();
    test_write_backpressure();
    test_read_latency();
    test_cal_gate();
    test_timeout();
    test_read_buffer();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
